// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor, out_diff = data_a - data_b, LSB first.
//            Operands are captured in parallel, walked through a one-bit full
//            subtractor with a registered borrow, and the difference is
//            re-assembled in parallel. busy/done handshake for a sequencer.
// Options  : SERIAL_SUB_OVF_EN - adds the signed-overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,       // asynchronous, active-low
    input  logic             load,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // One-bit full subtractor on the current LSBs and the stored borrow
    logic bit_diff;
    logic bit_borrow;
    assign bit_diff   = a_q[0] ^ b_q[0] ^ bw_q;
    assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: accept loads in IDLE/DONE, shift one bit per cycle in SHIFT
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (load) begin
                    state_d = S_SHIFT;
                    a_d     = data_a;
                    b_d     = data_b;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {bit_diff, res_q[WIDTH-1:1]};
                bw_d  = bit_borrow;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    diff_d  = {bit_diff, res_q[WIDTH-1:1]};
                    bout_d  = bit_borrow;
                    // On the last bit A[0]/B[0] hold the operand sign bits
                    ovf_d   = (a_q[0] != b_q[0]) && (bit_diff != a_q[0]);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign out_diff   = diff_q;
    assign borrow_out = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    assign overflow = ovf_q;
`else
    // Overflow tracking has no consumer in this build
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_a     (data_a),
        .data_b     (data_b),
        .busy       (busy),
        .done       (done),
        .out_diff   (out_diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called 1ns after a rising edge; returns 1ns after the edge following done
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_d, input logic exp_b, input bit glitch);
        int cyc;
        int busy_cnt;
        bit seen;
        load   = 1'b1;
        data_a = a;
        data_b = b;
        @(posedge clk); #1;
        load     = 1'b0;
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        seen     = 1'b0;
        while (!seen && cyc < 20) begin
            if (glitch && cyc == 1) begin
                load   = 1'b1;
                data_a = 4'd9;
                data_b = 4'd9;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        load = 1'b0;
        check({tag, " latency"}, cyc, 4);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " out_diff"}, out_diff, exp_d);
        check({tag, " borrow_out"}, borrow_out, exp_b);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, done, 0);
        check({tag, " idle_busy"}, busy, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        load   = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst out_diff", out_diff, 0);
        check("rst borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst overflow", overflow, 0);
`endif
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("5-3", 4'd5, 4'd3, 4'b0010, 1'b0, 1'b0);
        run_op("3-5", 4'd3, 4'd5, 4'b1110, 1'b1, 1'b0);
        run_op("0-1 glitch", 4'd0, 4'd1, 4'b1111, 1'b1, 1'b1);
        run_op("9-9", 4'd9, 4'd9, 4'b0000, 1'b0, 1'b0);

        // Load held high: done must appear on every fifth edge
        load   = 1'b1;
        data_a = 4'd15;
        data_b = 4'd1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            check($sformatf("held done k=%0d", k), done, ((k % 5) == 4) ? 1 : 0);
            if (done) check($sformatf("held diff k=%0d", k), out_diff, 4'b1110);
        end
        load = 1'b0;
        @(posedge clk); #1;

        // Reset during the second SHIFT cycle of 7-2
        load   = 1'b1;
        data_a = 4'd7;
        data_b = 4'd2;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort out_diff", out_diff, 0);
        check("abort borrow", borrow_out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort nodone k=%0d", k), done, 0);
        end
        run_op("7-2", 4'd7, 4'd2, 4'b0101, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        run_op("7-(-1)", 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b0);
        check("7-(-1) overflow", overflow, 1);
        run_op("3-1", 4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0);
        check("3-1 overflow", overflow, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
